// File: rtl/dvb_rsp_dma_pack.sv
// Buffers one DVB response frame behind a two-word header and streams it to the host DMA engine.
// Optional macro DVB_RSP_DROP_CNT_EN builds a saturating counter of dropped frames.
module dvb_rsp_dma_pack #(
  parameter int BUF_AW = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] dvb_rsp_din,
  input  logic        dvb_rsp_din_en,
  input  logic        dvb_rsp_sof,
  input  logic        dvb_rsp_eof,
  input  logic        dma_rd_start,
  input  logic        dma_rdata_rdy,
  output logic [63:0] dma_rdata,
  output logic        dma_rdata_en,
  output logic        rsp_pending,
  output logic [15:0] rsp_drop_cnt
);

  localparam int DEPTH = 1 << BUF_AW;
  localparam logic [BUF_AW:0] FULL_IDX  = (BUF_AW+1)'(DEPTH);
  localparam logic [BUF_AW:0] AFTER_SOF = (BUF_AW+1)'(3);

  typedef enum logic [1:0] {IDLE, FILL, PEND, SEND} state_t;

  state_t            state;
  logic [63:0]       buf_mem [DEPTH];
  logic [BUF_AW:0]   wr_idx;
  logic [BUF_AW-1:0] rd_idx;
  logic              ovf;
  logic [14:0]       rsp_len;
  logic [63:0]       rd_word;
  logic              wr_en;
  logic [BUF_AW-1:0] wr_addr;
  logic              sof_in;
  logic              last_word;

  assign sof_in    = dvb_rsp_din_en & dvb_rsp_sof;
  // wr_idx is the next free slot, which with the two header slots is also the frame length
  assign rsp_len   = 15'(wr_idx);
  assign last_word = (({1'b0, rd_idx} + (BUF_AW+1)'(1)) == wr_idx);

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = wr_idx[BUF_AW-1:0];
    if (dvb_rsp_din_en) begin
      if (dvb_rsp_sof && (state == IDLE || state == FILL)) begin
        wr_en   = 1'b1;
        wr_addr = BUF_AW'(2);
      end else if (state == FILL && wr_idx != FULL_IDX) begin
        wr_en = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !rst) buf_mem[wr_addr] <= dvb_rsp_din;
  end

  always_comb begin
    if (rd_idx == '0)
      rd_word = {24'd0, rsp_len[7:0], 1'b0, rsp_len[14:8], 16'd0, 8'h05};
    else if (rd_idx == BUF_AW'(1))
      rd_word = {63'd0, ovf};
    else
      rd_word = buf_mem[rd_idx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      wr_idx       <= '0;
      rd_idx       <= '0;
      ovf          <= 1'b0;
      rsp_pending  <= 1'b0;
      dma_rdata_en <= 1'b0;
      dma_rdata    <= '0;
    end else begin
      dma_rdata_en <= 1'b0;
      dma_rdata    <= '0;
      case (state)
        IDLE: begin
          if (sof_in) begin
            wr_idx <= AFTER_SOF;
            ovf    <= 1'b0;
            if (dvb_rsp_eof) begin
              state       <= PEND;
              rsp_pending <= 1'b1;
            end else begin
              state <= FILL;
            end
          end
        end
        FILL: begin
          if (sof_in) begin
            wr_idx <= AFTER_SOF;
            ovf    <= 1'b0;
            if (dvb_rsp_eof) begin
              state       <= PEND;
              rsp_pending <= 1'b1;
            end
          end else if (dvb_rsp_din_en) begin
            if (wr_idx == FULL_IDX) ovf <= 1'b1;
            else                    wr_idx <= wr_idx + (BUF_AW+1)'(1);
            if (dvb_rsp_eof) begin
              state       <= PEND;
              rsp_pending <= 1'b1;
            end
          end
        end
        PEND: begin
          if (dma_rd_start) begin
            state       <= SEND;
            rd_idx      <= '0;
            rsp_pending <= 1'b0;
          end
        end
        SEND: begin
          if (dma_rdata_rdy) begin
            dma_rdata_en <= 1'b1;
            dma_rdata    <= rd_word;
            rd_idx       <= rd_idx + BUF_AW'(1);
            if (last_word) begin
              state <= IDLE;
              ovf   <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DVB_RSP_DROP_CNT_EN
  // A new sof anywhere but IDLE abandons a frame: a partial one in FILL, the incoming one in PEND/SEND
  always_ff @(posedge clk) begin
    if (rst)
      rsp_drop_cnt <= '0;
    else if (sof_in && state != IDLE && rsp_drop_cnt != 16'hFFFF)
      rsp_drop_cnt <= rsp_drop_cnt + 16'd1;
  end
`else
  assign rsp_drop_cnt = '0;
`endif

endmodule

// File: tb/tb_dvb_rsp_dma_pack.sv
// Randomized bench for dvb_rsp_dma_pack (BUF_AW=4) against a queue-based frame model.
module tb_dvb_rsp_dma_pack;

  localparam int AW  = 4;
  localparam int CAP = (1 << AW) - 2;

  logic        clk;
  logic        rst;
  logic [63:0] dvb_rsp_din;
  logic        dvb_rsp_din_en;
  logic        dvb_rsp_sof;
  logic        dvb_rsp_eof;
  logic        dma_rd_start;
  logic        dma_rdata_rdy;
  logic [63:0] dma_rdata;
  logic        dma_rdata_en;
  logic        rsp_pending;
  logic [15:0] rsp_drop_cnt;

  int          check_count = 0;
  int          error_count = 0;
  int          exp_drops   = 0;
  logic [63:0] frame_q[$];
  logic [63:0] exp_words[$];

  dvb_rsp_dma_pack #(.BUF_AW(AW)) dut (
    .clk           (clk),
    .rst           (rst),
    .dvb_rsp_din   (dvb_rsp_din),
    .dvb_rsp_din_en(dvb_rsp_din_en),
    .dvb_rsp_sof   (dvb_rsp_sof),
    .dvb_rsp_eof   (dvb_rsp_eof),
    .dma_rd_start  (dma_rd_start),
    .dma_rdata_rdy (dma_rdata_rdy),
    .dma_rdata     (dma_rdata),
    .dma_rdata_en  (dma_rdata_en),
    .rsp_pending   (rsp_pending),
    .rsp_drop_cnt  (rsp_drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [63:0] exp_drop_cnt();
`ifdef DVB_RSP_DROP_CNT_EN
    return (exp_drops > 65535) ? 64'd65535 : 64'(exp_drops);
`else
    return 64'd0;
`endif
  endfunction

  // Inputs change only on the falling edge; outputs are also checked there
  task automatic applyStimulus(input logic [63:0] d, input logic en, input logic sof, input logic eof);
    @(negedge clk);
    dvb_rsp_din    = d;
    dvb_rsp_din_en = en;
    dvb_rsp_sof    = sof;
    dvb_rsp_eof    = eof;
    dma_rd_start   = 1'b0;
    dma_rdata_rdy  = 1'b0;
  endtask

  task automatic drive_idle();
    applyStimulus(64'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_words(input int n, input bit with_eof, input bit gaps, input bit keep);
    logic [63:0] w;
    if (keep) frame_q.delete();
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 2) == 0)
        applyStimulus(rand64(), 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      w = rand64();
      if (keep) frame_q.push_back(w);
      applyStimulus(w, 1'b1, i == 0, with_eof && (i == n - 1));
    end
    drive_idle();
  endtask

  // Reference: header with length/type, overflow word, then the payload that fits
  task automatic build_expected();
    int stored;
    int len;
    stored = (frame_q.size() > CAP) ? CAP : frame_q.size();
    len    = stored + 2;
    exp_words.delete();
    exp_words.push_back((64'(len % 256) << 32) | (64'(len / 256) << 24) | 64'h05);
    exp_words.push_back(64'(frame_q.size() > CAP));
    for (int i = 0; i < stored; i++) exp_words.push_back(frame_q[i]);
  endtask

  // mode 0: random rdy, 1: rdy always high, 2: rdy alternating 1,0
  task automatic read_frame(input int mode, input string tag);
    int   idx;
    int   cyc;
    logic r;
    build_expected();
    checkOutput({tag, " pending"}, 64'(rsp_pending), 64'd1);
    @(negedge clk);
    dma_rd_start = 1'b1;
    @(negedge clk);
    dma_rd_start = 1'b0;
    checkOutput({tag, " pending_drop"}, 64'(rsp_pending), 64'd0);
    checkOutput({tag, " en_at_start"}, 64'(dma_rdata_en), 64'd0);
    idx = 0;
    cyc = 0;
    while (idx < exp_words.size() && cyc < 400) begin
      case (mode)
        1:       r = 1'b1;
        2:       r = (cyc % 2 == 0);
        default: r = 1'($urandom_range(0, 1));
      endcase
      dma_rdata_rdy = r;
      @(negedge clk);
      cyc++;
      if (r) begin
        checkOutput($sformatf("%s en%0d", tag, idx), 64'(dma_rdata_en), 64'd1);
        checkOutput($sformatf("%s word%0d", tag, idx), dma_rdata, exp_words[idx]);
        idx++;
      end else begin
        checkOutput($sformatf("%s idle_en", tag), 64'(dma_rdata_en), 64'd0);
        checkOutput($sformatf("%s idle_data", tag), dma_rdata, 64'd0);
      end
    end
    if (idx < exp_words.size()) checkOutput({tag, " timeout"}, 64'(idx), 64'(exp_words.size()));
    dma_rdata_rdy = 1'b1;
    @(negedge clk);
    dma_rdata_rdy = 1'b0;
    checkOutput({tag, " en_after_last"}, 64'(dma_rdata_en), 64'd0);
    checkOutput({tag, " pending_after"}, 64'(rsp_pending), 64'd0);
    checkOutput({tag, " drop_cnt"}, 64'(rsp_drop_cnt), exp_drop_cnt());
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1;
    dvb_rsp_din = '0; dvb_rsp_din_en = 0; dvb_rsp_sof = 0; dvb_rsp_eof = 0;
    dma_rd_start = 0; dma_rdata_rdy = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checkOutput("reset en", 64'(dma_rdata_en), 64'd0);
    checkOutput("reset data", dma_rdata, 64'd0);
    checkOutput("reset pending", 64'(rsp_pending), 64'd0);
    checkOutput("reset drop_cnt", 64'(rsp_drop_cnt), 64'd0);

    // rd_start in IDLE and a stray word without sof must both be ignored
    dma_rd_start = 1'b1;
    @(negedge clk);
    dma_rd_start  = 1'b0;
    dma_rdata_rdy = 1'b1;
    @(negedge clk);
    dma_rdata_rdy = 1'b0;
    checkOutput("idle rd_start en", 64'(dma_rdata_en), 64'd0);
    checkOutput("idle rd_start pending", 64'(rsp_pending), 64'd0);
    applyStimulus(rand64(), 1'b1, 1'b0, 1'b1);
    drive_idle();
    checkOutput("stray word pending", 64'(rsp_pending), 64'd0);

    send_words(3, 1, 0, 1);
    read_frame(1, "three_word");
    send_words(1, 1, 0, 1);
    read_frame(1, "single_word");
    send_words(20, 1, 0, 1);
    read_frame(1, "overflow");
    send_words(3, 1, 0, 1);
    read_frame(1, "after_overflow");
    send_words(5, 1, 0, 1);
    read_frame(2, "rdy_toggle");

    send_words(3, 0, 0, 0);
    exp_drops++;
    send_words(4, 1, 0, 1);
    read_frame(0, "restart");

    send_words(4, 1, 0, 1);
    send_words(3, 1, 0, 0);
    exp_drops++;
    read_frame(1, "drop_in_pend");

    for (int t = 0; t < 30; t++) begin
      send_words($urandom_range(1, 20), 1, 1'($urandom_range(0, 1)), 1);
      if ($urandom_range(0, 3) == 0) begin
        send_words($urandom_range(1, 4), 1, 0, 0);
        exp_drops++;
      end
      read_frame($urandom_range(0, 2), $sformatf("rand%0d", t));
    end

    // Reset in the middle of a transfer
    send_words(6, 1, 0, 1);
    build_expected();
    @(negedge clk);
    dma_rd_start = 1'b1;
    @(negedge clk);
    dma_rd_start  = 1'b0;
    dma_rdata_rdy = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkOutput($sformatf("midsend word%0d", i), dma_rdata, exp_words[i]);
    end
    rst = 1'b1;
    dma_rdata_rdy = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_drops = 0;
    checkOutput("midsend rst en", 64'(dma_rdata_en), 64'd0);
    checkOutput("midsend rst data", dma_rdata, 64'd0);
    checkOutput("midsend rst pending", 64'(rsp_pending), 64'd0);
    checkOutput("midsend rst drop_cnt", 64'(rsp_drop_cnt), 64'd0);
    send_words(7, 1, 1, 1);
    read_frame(1, "after_reset");

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule

// File: doc/dvb_rsp_dma_pack.md
DVB_RSP_DMA_PACK -- requirements
Module: dvb_rsp_dma_pack

Interface
REQ-001 Parameter BUF_AW, default 8, sets buffer depth to 2^BUF_AW 64-bit words.
REQ-002 clk  input  1  clock; all logic on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 dvb_rsp_din  input  64  DVB response word from the command engine.
REQ-005 dvb_rsp_din_en  input  1  dvb_rsp_din valid.
REQ-006 dvb_rsp_sof / dvb_rsp_eof  input  1 each  first / last word of a response frame, qualified by dvb_rsp_din_en.
REQ-007 dma_rd_start  input  1  one-cycle pulse: host DMA read of the pending response begins.
REQ-008 dma_rdata_rdy  input  1  DMA engine accepts a word this cycle.
REQ-009 dma_rdata  output  64  word to host.
REQ-010 dma_rdata_en  output  1  dma_rdata valid.
REQ-011 rsp_pending  output  1  a complete frame is buffered and awaits the host.
REQ-012 rsp_drop_cnt  output  16  count of dropped frames (see Configuration).

Function
REQ-013 The block SHALL implement states IDLE, FILL, PEND and SEND.
REQ-014 IDLE: sof with din_en SHALL store word at buffer index 2 and go to FILL; sof together with eof SHALL go directly to PEND.
REQ-015 FILL: each din_en word SHALL be stored at the next index; eof SHALL go to PEND.
REQ-016 FILL: sof SHALL restart the frame at index 2 (the previous partial frame is discarded and counted as dropped).
REQ-017 Payload beyond 2^BUF_AW-2 words SHALL be discarded, the overflow flag SHALL be set, and reception SHALL continue until eof.
REQ-018 rsp_len (15 bits) SHALL equal the stored payload word count plus 2.
REQ-019 PEND: rsp_pending=1; dma_rd_start SHALL go to SEND with the word index at 0.
REQ-020 SEND: in each cycle with dma_rdata_rdy=1, the next cycle SHALL present one word with dma_rdata_en=1, words in index order. dma_rdata_en=0 in every cycle that does not follow an accepted rdy.
REQ-021 Word 0 SHALL have [7:0]=8'h05, [31:24]=rsp_len[14:8], [39:32]=rsp_len[7:0], and all other bits 0.
REQ-022 Word 1 SHALL have bit0 = overflow flag, and all other bits 0.
REQ-023 Words 2..rsp_len-1 SHALL be the payload, unmodified.
REQ-024 After word rsp_len-1 is presented, the FSM SHALL return to IDLE and clear the overflow flag; rsp_pending SHALL drop in the cycle SEND is entered.
REQ-025 An sof arriving in PEND or SEND SHALL drop that whole frame (through its eof) and increment the drop count; buffered data SHALL be untouched.
REQ-026 dma_rd_start outside PEND SHALL be ignored.
REQ-027 din_en without a preceding sof in IDLE SHALL be ignored.
REQ-028 dma_rdata SHALL be 0 whenever dma_rdata_en=0.

Reset
REQ-029 rst SHALL force IDLE and clear rsp_pending, dma_rdata_en, dma_rdata, the overflow flag, all indices and rsp_drop_cnt to 0 on the next edge, including mid-FILL or mid-SEND.
REQ-030 Buffer contents need not be cleared by reset.

Configuration
REQ-031 With macro DVB_RSP_DROP_CNT_EN defined, rsp_drop_cnt SHALL increment by 1 per dropped frame (REQ-016, REQ-025) and saturate at 16'hFFFF.
REQ-032 Without DVB_RSP_DROP_CNT_EN, rsp_drop_cnt SHALL be constant 0, no counter logic SHALL be built, and drop behaviour SHALL be otherwise identical.

Verification
REQ-033 Frame of 3 words (sof on A, B, eof on C), then rd_start, rdy=1 -> 5 words: {len=5, type 05}, 0, A, B, C; rsp_pending rises after eof and falls at SEND.
REQ-034 Single-word frame (sof+eof on D) -> header len=2+1=3, word1=0, word2=D.
REQ-035 BUF_AW=4, 20-word frame -> 14 payload words stored, len=16, word1 bit0=1, overflow flag cleared afterwards.
REQ-036 rdy toggling 1,0,1,0 during SEND -> dma_rdata_en pulses only after rdy=1 cycles; word order is preserved with no repeats.
REQ-037 Second frame during PEND -> ignored; first frame is read intact; rsp_drop_cnt=1 with the macro, 0 without.
REQ-038 rst asserted mid-SEND after 2 words -> next cycle IDLE, all outputs 0; a new frame is then accepted normally.
